// File: rtl/seq_reg_array.sv
// Serial-in symbol array: appends at the tail, pops from the head, exposes all entries in parallel.
// Optional sticky error flag for dropped/ignored operations under `SEQ_REG_ARRAY_ERR_EN.
module seq_reg_array #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   shift_en,
  input  logic                   clear,
  output logic [WIDTH-1:0]       data_out,
  output logic [WIDTH*DEPTH-1:0] q_flat,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty
`ifdef SEQ_REG_ARRAY_ERR_EN
  ,
  output logic                   err
`endif
);

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [WIDTH-1:0] entry_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop, do_push;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A pop frees the tail slot, so a full array still accepts a concurrent append.
  assign do_pop  = shift_en && !empty;
  assign do_push = valid && (!full || do_pop);

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) entry_d[i] = '0;
      count_d = '0;
    end else if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) entry_d[i] = entry_q[i + 1];
      entry_d[DEPTH-1] = '0;
      if (do_push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i + 1) == count_q) entry_d[i] = data_in;
        end
      end else begin
        count_d = count_q - 1'b1;
      end
    end else if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == count_q) entry_d[i] = data_in;
      end
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign q_flat[g*WIDTH +: WIDTH] = entry_q[g];
  end

  assign data_out = entry_q[0];
  assign count    = count_q;

`ifdef SEQ_REG_ARRAY_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (clear) begin
      err_q <= 1'b0;
    end else if ((valid && full && !shift_en) || (shift_en && empty && !valid)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_seq_reg_array.sv
// Randomized self-checking bench for seq_reg_array against a queue-based reference model.
// Checks the err output too when built with SEQ_REG_ARRAY_ERR_EN.
module tb_seq_reg_array;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   valid;
  logic [WIDTH-1:0]       data_in;
  logic                   shift_en;
  logic                   clear;
  logic [WIDTH-1:0]       data_out;
  logic [WIDTH*DEPTH-1:0] q_flat;
  logic [CNT_W-1:0]       count;
  logic                   full;
  logic                   empty;
`ifdef SEQ_REG_ARRAY_ERR_EN
  logic                   err;
`endif

  seq_reg_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .data_in  (data_in),
    .shift_en (shift_en),
    .clear    (clear),
    .data_out (data_out),
    .q_flat   (q_flat),
    .count    (count),
    .full     (full),
    .empty    (empty)
`ifdef SEQ_REG_ARRAY_ERR_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stored symbols oldest-first, plus sticky error flag.
  logic [WIDTH-1:0] model_q [$];
  logic             model_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic v, input logic [WIDTH-1:0] d, input logic s,
                            input logic c);
    bit can_pop, can_push;
    if (c) begin
      model_q.delete();
      model_err = 1'b0;
    end else begin
      if (v && model_q.size() == DEPTH && !s) model_err = 1'b1;
      if (s && model_q.size() == 0 && !v) model_err = 1'b1;
      can_pop  = s && model_q.size() > 0;
      can_push = v && (model_q.size() < DEPTH || can_pop);
      if (can_pop) void'(model_q.pop_front());
      if (can_push) model_q.push_back(d);
    end
  endtask

  task automatic check_all(input string tag);
    logic [WIDTH*DEPTH-1:0] exp_flat;
    logic [WIDTH-1:0]       exp_head;
    exp_flat = '0;
    foreach (model_q[i]) exp_flat[i*WIDTH +: WIDTH] = model_q[i];
    exp_head = (model_q.size() > 0) ? model_q[0] : '0;
    check_eq({tag, ".count"}, 64'(count), 64'(model_q.size()));
    check_eq({tag, ".q_flat"}, 64'(q_flat), 64'(exp_flat));
    check_eq({tag, ".data_out"}, 64'(data_out), 64'(exp_head));
    check_eq({tag, ".full"}, 64'(full), 64'(model_q.size() == DEPTH));
    check_eq({tag, ".empty"}, 64'(empty), 64'(model_q.size() == 0));
`ifdef SEQ_REG_ARRAY_ERR_EN
    check_eq({tag, ".err"}, 64'(err), 64'(model_err));
`endif
  endtask

  // Drive one cycle, advance the model on the edge, sample 1 time unit later.
  task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d,
                      input logic s, input logic c);
    valid    = v;
    data_in  = d;
    shift_en = s;
    clear    = c;
    @(posedge clk);
    model_step(v, d, s, c);
    #1;
    check_all(tag);
    valid    = 1'b0;
    shift_en = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_q.delete();
    model_err = 1'b0;
    #1;
    check_all("reset_async");
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    int pv;
    int ps;
    reset     = 1'b0;
    valid     = 1'b0;
    data_in   = '0;
    shift_en  = 1'b0;
    clear     = 1'b0;
    model_err = 1'b0;
    #12;
    check_all("reset");
    reset = 1'b1;

    // Load 0,1,2,3.
    for (int i = 0; i < 4; i++) step("load4", 1'b1, WIDTH'(i), 1'b0, 1'b0);
    check_eq("load4.byte0", 64'(q_flat[7:0]), 64'h e4);

    // Two pops: head walks to 1 then 2.
    step("pop1", 1'b0, '0, 1'b1, 1'b0);
    check_eq("pop1.head", 64'(data_out), 64'd1);
    step("pop2", 1'b0, '0, 1'b1, 1'b0);
    check_eq("pop2.head", 64'(data_out), 64'd2);

    // Rebuild {1,2}, then simultaneous append 3 + pop -> {2,3}.
    step("clr", 1'b0, '0, 1'b0, 1'b1);
    step("ld1", 1'b1, 2'd1, 1'b0, 1'b0);
    step("ld2", 1'b1, 2'd2, 1'b0, 1'b0);
    step("pushpop", 1'b1, 2'd3, 1'b1, 1'b0);
    check_eq("pushpop.entries", 64'(q_flat[3:0]), 64'h e);

    // Pop and shift on empty.
    step("clr2", 1'b0, '0, 1'b0, 1'b1);
    step("pop_empty", 1'b0, '0, 1'b1, 1'b0);
    step("clr3", 1'b0, '0, 1'b0, 1'b1);

    // Fill to DEPTH, then one more append is dropped.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    step("overflow", 1'b1, 2'd3, 1'b0, 1'b0);
    step("full_pushpop", 1'b1, 2'd3, 1'b1, 1'b0);

    // Clear wins over append and pop.
    step("clr4", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("ld5", 1'b1, WIDTH'(i + 1), 1'b0, 1'b0);
    step("clear_prio", 1'b1, 2'd3, 1'b1, 1'b1);

    // Async reset mid-load, then reload restarts at entry 0.
    for (int i = 0; i < 3; i++) step("ld3", 1'b1, WIDTH'(i + 1), 1'b0, 1'b0);
    do_reset();
    step("reload", 1'b1, 2'd2, 1'b0, 1'b0);

    // Randomized phases biased toward filling, draining and mixed traffic.
    for (int ph = 0; ph < 12; ph++) begin
      case (ph % 3)
        0:       begin pv = 85; ps = 15; end
        1:       begin pv = 15; ps = 85; end
        default: begin pv = 60; ps = 50; end
      endcase
      for (int c = 0; c < 50; c++) begin
        step("rand", ($urandom_range(0, 99) < pv), WIDTH'($urandom),
             ($urandom_range(0, 99) < ps), ($urandom_range(0, 99) < 2));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
